// File: rtl/sha256_round_engine.sv
// sha256_round_engine: self-sequencing SHA-256 (optionally SHA-224) compression engine.
// Takes 16 streamed 32-bit words per block, chains blocks, runs UNROLL rounds per clock.
// Optional feature macro: SHA224_EN (SHA-224 IV selection and output masking).
module sha256_round_engine #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         mode_224,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_word,
    input  logic         in_last,
    output logic         busy,
    output logic         digest_valid,
    output logic [255:0] digest
);

    generate
        if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
            $error("sha256_round_engine: UNROLL must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, UPDATE, DONE} state_t;

    localparam logic [0:7][31:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
`ifdef SHA224_EN
    localparam logic [0:7][31:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
`endif

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Slide the schedule window by UNROLL entries; new entries chain on each other
    // when UNROLL > 2 (W[t+18] needs W[t+16]).
    function automatic logic [0:15][31:0] next_win(input logic [0:15][31:0] w);
        logic [31:0] x [16+UNROLL];
        for (int i = 0; i < 16; i++) x[i] = w[i];
        for (int j = 0; j < UNROLL; j++)
            x[16+j] = ssig1(x[14+j]) + x[9+j] + ssig0(x[1+j]) + x[j];
        for (int i = 0; i < 16; i++) next_win[i] = x[i+UNROLL];
    endfunction

    // UNROLL chained compression rounds starting at round t0; w[0] holds W[t0].
    function automatic logic [0:7][31:0] rounds(input logic [0:7][31:0] s_in,
                                                input logic [0:15][31:0] w,
                                                input logic [5:0] t0);
        logic [0:7][31:0] s;
        logic [31:0]      t1, t2;
        logic [5:0]       ki;
        s = s_in;
        for (int j = 0; j < UNROLL; j++) begin
            ki = t0 + 6'(j);
            t1 = s[7] + bsig1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + K[ki] + w[j];
            t2 = bsig0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
            s  = {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
        end
        return s;
    endfunction

    state_t            state;
    logic [0:7][31:0]  hs;        // chaining value H0..H7
    logic [0:7][31:0]  wv;        // working variables A..H
    logic [0:15][31:0] win;       // schedule window, win[0] = W[t]
    logic [3:0]        word_cnt;
    logic [5:0]        t;
    logic              last_blk;
    logic [0:7][31:0]  iv;

`ifdef SHA224_EN
    logic mode;
    assign iv = mode_224 ? IV224 : IV256;
`else
    logic unused_mode;
    assign unused_mode = mode_224;
    assign iv          = IV256;
`endif

    assign in_ready = (state == LOAD);
    assign busy     = (state != IDLE);

    // Main sequencer: word loading, round iteration, chaining update, digest publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hs           <= '0;
            wv           <= '0;
            win          <= '0;
            word_cnt     <= '0;
            t            <= '0;
            last_blk     <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
`ifdef SHA224_EN
            mode         <= 1'b0;
`endif
        end else begin
            digest_valid <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        hs       <= iv;
                        word_cnt <= '0;
                        state    <= LOAD;
`ifdef SHA224_EN
                        mode     <= mode_224;
`endif
                    end
                    LOAD: if (in_valid) begin
                        win      <= {win[1:15], in_word};
                        word_cnt <= word_cnt + 4'd1;
                        if (word_cnt == 4'd15) begin
                            last_blk <= in_last;
                            wv       <= hs;
                            t        <= '0;
                            state    <= ROUND;
                        end
                    end
                    ROUND: begin
                        wv  <= rounds(wv, win, t);
                        win <= next_win(win);
                        t   <= t + 6'(UNROLL);
                        if (t == 6'(64 - UNROLL)) state <= UPDATE;
                    end
                    UPDATE: begin
                        for (int i = 0; i < 8; i++) hs[i] <= hs[i] + wv[i];
                        word_cnt <= '0;
                        state    <= last_blk ? DONE : LOAD;
                    end
                    DONE: begin
`ifdef SHA224_EN
                        digest <= mode ? {hs[0:6], 32'h0} : hs;
`else
                        digest <= hs;
`endif
                        digest_valid <= 1'b1;
                        state        <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
